// File: rtl/mips_ctl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: FSM state
// encoding, opcode and funct constants, ALUOp / ALUCtl codes, and the
// ALUSrcB / PCSource mux encodings used by the datapath.
package mips_ctl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_alu_ctl.sv
// ALU control decoder: maps the FSM's ALUOp plus the instruction funct
// field to an ALU operation code. Purely combinational.
//   alu_op  in  2         00 = add, 01 = sub, 10 = decode funct
//   funct   in  FUNCT_W   IR[5:0]
//   alu_ctl out ALUCTL_W  ALU operation
module mips_alu_ctl
  import mips_ctl_pkg::*;
#(
  parameter int FUNCT_W  = 6,
  parameter int ALUCTL_W = 3
) (
  input  logic [1:0]          alu_op,
  input  logic [FUNCT_W-1:0]  funct,
  output logic [ALUCTL_W-1:0] alu_ctl
);

  always_comb begin
    alu_ctl = ALUCTL_W'(ALU_ADD);
    case (alu_op)
      ALUOP_SUB: alu_ctl = ALUCTL_W'(ALU_SUB);
      ALUOP_FUNCT: begin
        case (funct)
          F_ADD:   alu_ctl = ALUCTL_W'(ALU_ADD);
          F_SUB:   alu_ctl = ALUCTL_W'(ALU_SUB);
          F_AND:   alu_ctl = ALUCTL_W'(ALU_AND);
          F_OR:    alu_ctl = ALUCTL_W'(ALU_OR);
          F_SLT:   alu_ctl = ALUCTL_W'(ALU_SLT);
          // Unknown funct falls back to add; it is not trapped.
          default: alu_ctl = ALUCTL_W'(ALU_ADD);
        endcase
      end
      default: alu_ctl = ALUCTL_W'(ALU_ADD);
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control unit. One FSM walks each instruction through
// fetch, decode, execute, memory and writeback (3-5 cycles plus memory
// wait states) and drives the shared-memory datapath strobes and muxes.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   Op, Funct           IR[31:26] (sampled in DECODE), IR[5:0] (used in EXEC)
//   mem_ready           memory access completes this cycle
//   PCWrite..PCSource   datapath controls
//   ALUCtl              ALU operation
//   state               current FSM state (debug)
//   illegal             trap reached; held until reset
//   instr_count         retired-instruction counter (wraps)
//
// Memory handshake: a request (MemRead or MemWrite, in FETCH, MEMRD or
// MEMWR) is held steady every cycle until the cycle in which mem_ready is
// 1; that cycle completes the access and the FSM advances on its edge.
// mem_ready is ignored in all other states.
module mips_multicycle_control
  import mips_ctl_pkg::*;
#(
  parameter int OP_W     = 6,
  parameter int FUNCT_W  = 6,
  parameter int ALUCTL_W = 3,
  parameter int CNT_W    = 32,
  parameter bit EN_ADDI  = 1'b1,
  parameter bit EN_JUMP  = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OP_W-1:0]     Op,
  input  logic [FUNCT_W-1:0]  Funct,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                MemtoReg,
  output logic                RegWrite,
  output logic                RegDst,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          PCSource,
  output logic [ALUCTL_W-1:0] ALUCtl,
  output logic [3:0]          state,
  output logic                illegal,
  output logic [CNT_W-1:0]    instr_count
);

  state_t     cur_state, nxt_state;
  logic       mem_is_store;
  logic       retire;
  logic [1:0] alu_op;
  logic       pc_write_s, pc_write_cond_s, mem_read_s, mem_write_s;
  logic       ir_write_s, reg_write_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state    <= S_FETCH;
      mem_is_store <= 1'b0;
      instr_count  <= '0;
    end else begin
      cur_state <= nxt_state;
      // Op is only valid in DECODE, so remember lw vs sw for MEMADR.
      if (cur_state == S_DECODE) mem_is_store <= (Op == OP_SW);
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
  end

  always_comb begin
    nxt_state       = cur_state;
    retire          = 1'b0;
    alu_op          = ALUOP_ADD;
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    mem_read_s      = 1'b0;
    mem_write_s     = 1'b0;
    ir_write_s      = 1'b0;
    reg_write_s     = 1'b0;
    IorD            = 1'b0;
    MemtoReg        = 1'b0;
    RegDst          = 1'b0;
    ALUSrcA         = 1'b0;
    ALUSrcB         = SRCB_B;
    PCSource        = PCSRC_ALU;
    case (cur_state)
      S_FETCH: begin
        mem_read_s = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        // PC+4 and IR load happen only on the cycle the fetch completes.
        ir_write_s = mem_ready;
        pc_write_s = mem_ready;
        if (mem_ready) nxt_state = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMM_SH;
        if (Op == OP_LW || Op == OP_SW)  nxt_state = S_MEMADR;
        else if (Op == OP_RTYPE)         nxt_state = S_EXEC;
        else if (Op == OP_BEQ)           nxt_state = S_BRANCH;
        else if (EN_ADDI && Op == OP_ADDI) nxt_state = S_ADDIEX;
        else if (EN_JUMP && Op == OP_J)  nxt_state = S_JUMP;
        else                             nxt_state = S_TRAP;
      end
      S_MEMADR: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_IMM;
        nxt_state = mem_is_store ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read_s = 1'b1;
        IorD       = 1'b1;
        if (mem_ready) nxt_state = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write_s = 1'b1;
        MemtoReg    = 1'b1;
        retire      = 1'b1;
        nxt_state   = S_FETCH;
      end
      S_MEMWR: begin
        mem_write_s = 1'b1;
        IorD        = 1'b1;
        if (mem_ready) begin
          retire    = 1'b1;
          nxt_state = S_FETCH;
        end
      end
      S_EXEC: begin
        ALUSrcA   = 1'b1;
        alu_op    = ALUOP_FUNCT;
        nxt_state = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
        RegDst      = 1'b1;
        retire      = 1'b1;
        nxt_state   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA         = 1'b1;
        alu_op          = ALUOP_SUB;
        pc_write_cond_s = 1'b1;
        PCSource        = PCSRC_ALUOUT;
        retire          = 1'b1;
        nxt_state       = S_FETCH;
      end
      S_ADDIEX: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_IMM;
        nxt_state = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_s = 1'b1;
        retire      = 1'b1;
        nxt_state   = S_FETCH;
      end
      S_JUMP: begin
        pc_write_s = 1'b1;
        PCSource   = PCSRC_JUMP;
        retire     = 1'b1;
        nxt_state  = S_FETCH;
      end
      S_TRAP:  nxt_state = S_TRAP;
      default: nxt_state = S_FETCH;
    endcase
  end

  // Architectural write/request strobes are killed combinationally while
  // reset is asserted, so a reset mid-instruction can never write.
  assign PCWrite     = pc_write_s & rst_n;
  assign PCWriteCond = pc_write_cond_s & rst_n;
  assign MemRead     = mem_read_s & rst_n;
  assign MemWrite    = mem_write_s & rst_n;
  assign IRWrite     = ir_write_s & rst_n;
  assign RegWrite    = reg_write_s & rst_n;

  assign state   = cur_state;
  // TRAP is absorbing, so this stays high until reset.
  assign illegal = (cur_state == S_TRAP);

  mips_alu_ctl #(
    .FUNCT_W  (FUNCT_W),
    .ALUCTL_W (ALUCTL_W)
  ) u_alu_ctl (
    .alu_op  (alu_op),
    .funct   (Funct),
    .alu_ctl (ALUCtl)
  );

endmodule

// File: tb/tb_mips_multicycle_control.sv
module tb_mips_multicycle_control;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [5:0] op, funct;
  logic       mem_ready;

  logic pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic mem_to_reg, reg_write, reg_dst, alu_src_a;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_ctl;
  logic [3:0] state;
  logic illegal;
  logic [31:0] instr_count;

  logic d_pcw, d_pcwc, d_iord, d_mrd, d_mwr, d_irw, d_m2r, d_rw, d_rdst, d_srca;
  logic [1:0] d_srcb, d_pcsrc;
  logic [2:0] d_aluctl;
  logic [3:0] d_state;
  logic d_illegal;
  logic [31:0] d_count;

  mips_multicycle_control u_dut (
    .clk(clk), .rst_n(rst_n), .Op(op), .Funct(funct), .mem_ready(mem_ready),
    .PCWrite(pc_write), .PCWriteCond(pc_write_cond), .IorD(iord),
    .MemRead(mem_read), .MemWrite(mem_write), .IRWrite(ir_write),
    .MemtoReg(mem_to_reg), .RegWrite(reg_write), .RegDst(reg_dst),
    .ALUSrcA(alu_src_a), .ALUSrcB(alu_src_b), .PCSource(pc_source),
    .ALUCtl(alu_ctl), .state(state), .illegal(illegal),
    .instr_count(instr_count)
  );

  // Variant with addi and j disabled, fed the same stimulus.
  mips_multicycle_control #(.EN_ADDI(1'b0), .EN_JUMP(1'b0)) u_dis (
    .clk(clk), .rst_n(rst_n), .Op(op), .Funct(funct), .mem_ready(mem_ready),
    .PCWrite(d_pcw), .PCWriteCond(d_pcwc), .IorD(d_iord),
    .MemRead(d_mrd), .MemWrite(d_mwr), .IRWrite(d_irw),
    .MemtoReg(d_m2r), .RegWrite(d_rw), .RegDst(d_rdst),
    .ALUSrcA(d_srca), .ALUSrcB(d_srcb), .PCSource(d_pcsrc),
    .ALUCtl(d_aluctl), .state(d_state), .illegal(d_illegal),
    .instr_count(d_count)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_count = 0;
  logic [4:0] exp_q[$];   // {mem_ready to drive, expected state}
  bit tie_ready = 1'b0;   // drive mem_ready=1 outside memory phases

  // ---------------- reference model ----------------
  // Expected {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,
  // RegWrite,RegDst,ALUSrcA,ALUSrcB,PCSource} for a phase.
  function automatic logic [13:0] exp_strobes(input int st, input logic mr);
    logic pcw, pcwc, io, mrd, mwr, irw, m2r, rw, rd, sa;
    logic [1:0] sb, ps;
    {pcw, pcwc, io, mrd, mwr, irw, m2r, rw, rd, sa} = '0;
    sb = 2'b00; ps = 2'b00;
    case (st)
      0:  begin mrd = 1; sb = 2'b01; pcw = mr; irw = mr; end
      1:  sb = 2'b11;
      2, 9: begin sa = 1; sb = 2'b10; end
      3:  begin mrd = 1; io = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; io = 1; end
      6:  sa = 1;
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; pcwc = 1; ps = 2'b01; end
      10: rw = 1;
      11: begin pcw = 1; ps = 2'b10; end
      default: ;
    endcase
    return {pcw, pcwc, io, mrd, mwr, irw, m2r, rw, rd, sa, sb, ps};
  endfunction

  // Expected ALU operation; -1 where the phase leaves it unspecified.
  function automatic int exp_alu(input int st, input logic [5:0] f);
    case (st)
      0, 1, 2, 9: return 2;
      8: return 6;
      6: case (f)
           6'b100000: return 2;
           6'b100010: return 6;
           6'b100100: return 0;
           6'b100101: return 1;
           6'b101010: return 7;
           default:   return 2;
         endcase
      default: return -1;
    endcase
  endfunction

  function automatic logic filler();
    return tie_ready ? 1'b1 : 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(input int st, input logic mr);
    exp_q.push_back({mr, 4'(st)});
  endfunction

  // Builds the phase list of one instruction; returns 1 if it retires.
  function automatic bit build(input logic [5:0] o, input int wf, input int wm);
    repeat (wf) push(0, 1'b0);
    push(0, 1'b1);
    push(1, filler());
    case (o)
      LW:   begin push(2, filler()); repeat (wm) push(3, 1'b0); push(3, 1'b1); push(4, filler()); end
      SW:   begin push(2, filler()); repeat (wm) push(5, 1'b0); push(5, 1'b1); end
      RT:   begin push(6, filler()); push(7, filler()); end
      BEQ:  push(8, filler());
      ADDI: begin push(9, filler()); push(10, filler()); end
      JMP:  push(11, filler());
      default: begin repeat (10) push(12, filler()); return 1'b0; end
    endcase
    return 1'b1;
  endfunction

  // ---------------- driver ----------------
  // Entered and left at posedge+1 with the DUT in FETCH (or TRAP).
  // abort_st: assert reset during that phase (15 = never).
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                           input int wf, input int wm, input int abort_st);
    logic [4:0] item;
    logic [13:0] obs, exp_s;
    int ea;
    bit retires;
    op = o; funct = f;
    exp_q.delete();
    retires = build(o, wf, wm);
    while (exp_q.size() > 0) begin
      item = exp_q.pop_front();
      mem_ready = item[4];
      @(negedge clk);
      checks++;
      if (state !== item[3:0]) begin
        errors++;
        $display("FAIL state op=%b: got %0d expected %0d", o, state, item[3:0]);
      end
      obs = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
             mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, pc_source};
      exp_s = exp_strobes(int'(item[3:0]), item[4]);
      checks++;
      if (obs !== exp_s) begin
        errors++;
        $display("FAIL strobes op=%b st=%0d: got %b expected %b", o, item[3:0], obs, exp_s);
      end
      checks++;
      if (illegal !== (item[3:0] == 4'd12)) begin
        errors++;
        $display("FAIL illegal st=%0d: got %b", item[3:0], illegal);
      end
      ea = exp_alu(int'(item[3:0]), f);
      if (ea >= 0) begin
        checks++;
        if (alu_ctl !== 3'(ea)) begin
          errors++;
          $display("FAIL aluctl st=%0d funct=%b: got %b expected %b", item[3:0], f, alu_ctl, 3'(ea));
        end
      end
      if (int'(item[3:0]) == abort_st) begin
        rst_n = 1'b0;
        #1;
        checks++;
        if (state !== 4'd0 || {pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write} !== 6'b0) begin
          errors++;
          $display("FAIL abort_reset: state %0d strobes %b expected 0 and 000000", state,
                   {pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write});
        end
        @(posedge clk); #1;
        exp_count = 0;
        checks++;
        if (instr_count !== exp_count) begin
          errors++;
          $display("FAIL abort_count: got %0d expected 0", instr_count);
        end
        rst_n = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
    if (retires) exp_count++;
    checks++;
    if (instr_count !== exp_count) begin
      errors++;
      $display("FAIL instr_count op=%b: got %0d expected %0d", o, instr_count, exp_count);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #2;
    checks++;
    if (state !== 4'd0 || illegal !== 1'b0 ||
        {pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: state %0d illegal %b strobes %b expected 0 0 000000", state, illegal,
               {pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write});
    end
    @(posedge clk); #1;
    exp_count = 0;
    checks++;
    if (instr_count !== exp_count) begin
      errors++;
      $display("FAIL reset_count: got %0d expected 0", instr_count);
    end
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    op = 6'b0; funct = 6'b0;
    do_reset();
  endtask

  task automatic test_lw();
    tie_ready = 1'b1;
    run_instr(LW, 6'b0, 0, 0, 15);
    tie_ready = 1'b0;
  endtask

  task automatic test_sw_wait();
    run_instr(SW, 6'b0, 0, 2, 15);
  endtask

  task automatic test_rtype_slt();
    run_instr(RT, 6'b101010, 0, 0, 15);
  endtask

  task automatic test_beq_j();
    run_instr(BEQ, 6'b0, 1, 0, 15);
    run_instr(JMP, 6'b0, 0, 0, 15);
  endtask

  task automatic test_reset_mid_exec();
    run_instr(RT, 6'b100100, 0, 0, 6);
    run_instr(LW, 6'b0, 1, 1, 15);
  endtask

  task automatic test_random();
    logic [5:0] ops[6];
    logic [5:0] fns[6];
    logic [5:0] f;
    ops = '{LW, SW, RT, BEQ, ADDI, JMP};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
    for (int i = 0; i < 40; i++) begin
      f = fns[$urandom_range(0, 5)];
      if ($urandom_range(0, 4) == 0) f = 6'($urandom);
      run_instr(ops[$urandom_range(0, 5)], f, $urandom_range(0, 2), $urandom_range(0, 2), 15);
    end
  endtask

  task automatic test_illegal();
    run_instr(6'b111111, 6'b0, 0, 0, 15);
    @(negedge clk);
    checks++;
    if (illegal !== 1'b1 || state !== 4'd12) begin
      errors++;
      $display("FAIL trap_sticky: illegal %b state %0d expected 1 12", illegal, state);
    end
    @(posedge clk); #1;
    do_reset();
  endtask

  task automatic test_disabled();
    run_instr(ADDI, 6'b0, 0, 0, 15);
    checks++;
    if (d_state !== 4'd12 || d_illegal !== 1'b1 || {d_mrd, d_mwr, d_rw, d_pcw} !== 4'b0) begin
      errors++;
      $display("FAIL disabled_addi: state %0d illegal %b expected 12 1", d_state, d_illegal);
    end
    do_reset();
    run_instr(JMP, 6'b0, 0, 0, 15);
    checks++;
    if (d_state !== 4'd12 || d_illegal !== 1'b1 || d_count !== 32'd0) begin
      errors++;
      $display("FAIL disabled_j: state %0d illegal %b count %0d expected 12 1 0", d_state, d_illegal, d_count);
    end
    do_reset();
  endtask

  initial begin
    rst_n = 1'b1; mem_ready = 1'b0; op = 6'b0; funct = 6'b0;
    #1;
    test_reset();
    test_lw();
    test_sw_wait();
    test_rtype_slt();
    test_beq_j();
    test_reset_mid_exec();
    test_random();
    test_illegal();
    test_disabled();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
